fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, hands fetched
// words to decode through a single output register plus a one-entry skid,
// and squashes wrong-path data when a redirect arrives.
//
// state     | meaning
// FETCH     | request outstanding at fetch_pc
// WAIT_SLOT | word parked in skid, waiting for decode to free the output slot
// DISCARD   | redirected while a request is in flight; drop its data when it lands
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ins_ready_i,
  input  logic [31:0] instr_i,
  output logic        ins_req_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_SLOT = 2'd1,
    DISCARD   = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] skid_q, skid_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  logic [31:0] redirect_pc_al;
  logic        slot_free;

  assign redirect_pc_al = {redirect_pc_i[31:2], 2'b00};
  assign slot_free      = ~valid_q | ~stall_i;

  // Next-state and datapath: redirect beats any load, a transfer empties the slot
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    skid_d       = skid_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    valid_d      = valid_q;

    if (valid_q && !stall_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      FETCH: begin
        if (ins_ready_i) begin
          if (redirect_i) begin
            fetch_pc_d = redirect_pc_al;
          end else if (slot_free) begin
            instr_d    = instr_i;
            instr_pc_d = fetch_pc_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            skid_d       = instr_i;
            pending_pc_d = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + 32'd4;
            state_d      = WAIT_SLOT;
          end
        end else if (redirect_i) begin
          pending_pc_d = redirect_pc_al;
          state_d      = DISCARD;
        end
      end
      WAIT_SLOT: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_al;
          state_d    = FETCH;
        end else if (!stall_i) begin
          instr_d    = skid_q;
          instr_pc_d = pending_pc_q;
          valid_d    = 1'b1;
          state_d    = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_i) begin
          pending_pc_d = redirect_pc_al;
        end
        if (ins_ready_i) begin
          fetch_pc_d = redirect_i ? redirect_pc_al : pending_pc_q;
          state_d    = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (redirect_i) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      fetch_pc_q   <= RESET_PC_AL;
      pending_pc_q <= RESET_PC_AL;
      skid_q       <= 32'd0;
      valid_q      <= 1'b0;
      instr_q      <= 32'd0;
      instr_pc_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  // Request is gated by reset so it drops immediately and rises on the first free cycle
  assign ins_req_o  = ~rst_i & (state_q != WAIT_SLOT);
  assign pc_o       = fetch_pc_q;
  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign instr_pc_o = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each scenario starts from reset, drives one
// cycle at a time and checks outputs 1 ns after the rising edge.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ins_ready_i;
  logic [31:0] instr_i;
  logic        ins_req_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ins_ready_i   (ins_ready_i),
    .instr_i       (instr_i),
    .ins_req_o     (ins_req_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] ins, input logic stl,
                       input logic rd, input logic [31:0] rpc);
    ins_ready_i   = rdy;
    instr_i       = ins;
    stall_i       = stl;
    redirect_i    = rd;
    redirect_pc_i = rpc;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] pc,
                         input logic vld);
    check_eq({tag, ".req"},   {31'd0, ins_req_o}, {31'd0, req});
    check_eq({tag, ".pc"},    pc_o, pc);
    check_eq({tag, ".valid"}, {31'd0, valid_o}, {31'd0, vld});
  endtask

  task automatic chk_data(input string tag, input logic [31:0] ins, input logic [31:0] ipc);
    check_eq({tag, ".instr"},    instr_o, ins);
    check_eq({tag, ".instr_pc"}, instr_pc_o, ipc);
  endtask

  // Reset is held across one edge, then released 1 ns after the next edge
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #2;
    chk_out({tag, ".rst"}, 1'b0, 32'h0, 1'b0);
    chk_data({tag, ".rst"}, 32'h0, 32'h0);
    tick();
    rst_i = 1'b0;
    #0;
    chk_out({tag, ".first"}, 1'b1, 32'h0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    tick();

    // back-to-back fetch
    do_reset("seq");
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'd0); tick();
    chk_out("seq1", 1'b1, 32'h4, 1'b1); chk_data("seq1", mem_word(32'h0), 32'h0);
    drive(1'b1, mem_word(32'h4), 1'b0, 1'b0, 32'd0); tick();
    chk_out("seq2", 1'b1, 32'h8, 1'b1); chk_data("seq2", mem_word(32'h4), 32'h4);
    drive(1'b1, mem_word(32'h8), 1'b0, 1'b0, 32'd0); tick();
    chk_out("seq3", 1'b1, 32'hC, 1'b1); chk_data("seq3", mem_word(32'h8), 32'h8);

    // slow memory: request held stable until ready
    do_reset("slow");
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'd0); tick();
    chk_out("slow0", 1'b1, 32'h4, 1'b1);
    drive(1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0); tick();
    chk_out("slow1", 1'b1, 32'h4, 1'b0);
    drive(1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0); tick();
    chk_out("slow2", 1'b1, 32'h4, 1'b0);
    drive(1'b1, mem_word(32'h4), 1'b0, 1'b0, 32'd0); tick();
    chk_out("slow3", 1'b1, 32'h8, 1'b1); chk_data("slow3", mem_word(32'h4), 32'h4);
    drive(1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0); tick();
    chk_out("slow4", 1'b1, 32'h8, 1'b0);

    // stall with data returning: skid then drain
    do_reset("skid");
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'd0); tick();
    drive(1'b1, mem_word(32'h4), 1'b0, 1'b0, 32'd0); tick();
    chk_out("skid0", 1'b1, 32'h8, 1'b1); chk_data("skid0", mem_word(32'h4), 32'h4);
    drive(1'b1, 32'hAAAA0001, 1'b1, 1'b0, 32'd0); tick();
    chk_out("skid1", 1'b0, 32'hC, 1'b1); chk_data("skid1", mem_word(32'h4), 32'h4);
    drive(1'b1, 32'h11111111, 1'b1, 1'b0, 32'd0); tick();
    chk_out("skid2", 1'b0, 32'hC, 1'b1); chk_data("skid2", mem_word(32'h4), 32'h4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0); tick();
    chk_out("skid3", 1'b1, 32'hC, 1'b1); chk_data("skid3", 32'hAAAA0001, 32'h8);
    drive(1'b1, mem_word(32'hC), 1'b0, 1'b0, 32'd0); tick();
    chk_out("skid4", 1'b1, 32'h10, 1'b1); chk_data("skid4", mem_word(32'hC), 32'hC);

    // redirect while request outstanding: old data discarded, target aligned
    do_reset("disc");
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'd0); tick();
    drive(1'b1, mem_word(32'h4), 1'b0, 1'b0, 32'd0); tick();
    chk_out("disc0", 1'b1, 32'h8, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h103); tick();
    chk_out("disc1", 1'b1, 32'h8, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0); tick();
    chk_out("disc2", 1'b1, 32'h8, 1'b0);
    drive(1'b1, 32'hBAD00008, 1'b0, 1'b0, 32'd0); tick();
    chk_out("disc3", 1'b1, 32'h100, 1'b0);
    drive(1'b1, mem_word(32'h100), 1'b0, 1'b0, 32'd0); tick();
    chk_out("disc4", 1'b1, 32'h104, 1'b1); chk_data("disc4", mem_word(32'h100), 32'h100);

    // wrap at top of address space
    do_reset("wrap");
    drive(1'b1, 32'hBAD00000, 1'b0, 1'b1, 32'hFFFFFFFC); tick();
    chk_out("wrap0", 1'b1, 32'hFFFFFFFC, 1'b0);
    drive(1'b1, mem_word(32'hFFFFFFFC), 1'b0, 1'b0, 32'd0); tick();
    chk_out("wrap1", 1'b1, 32'h0, 1'b1); chk_data("wrap1", mem_word(32'hFFFFFFFC), 32'hFFFFFFFC);
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'd0); tick();
    chk_out("wrap2", 1'b1, 32'h4, 1'b1); chk_data("wrap2", mem_word(32'h0), 32'h0);

    // asynchronous reset while parked in WAIT_SLOT
    do_reset("arst");
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'd0); tick();
    drive(1'b1, 32'h5C1D0004, 1'b1, 1'b0, 32'd0); tick();
    chk_out("arst0", 1'b0, 32'h8, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_out("arst1", 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    tick();
    rst_i = 1'b0;
    #0;
    chk_out("arst2", 1'b1, 32'h0, 1'b0);
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, 32'd0); tick();
    chk_out("arst3", 1'b1, 32'h4, 1'b1); chk_data("arst3", mem_word(32'h0), 32'h0);
    drive(1'b1, mem_word(32'h4), 1'b0, 1'b0, 32'd0); tick();
    chk_out("arst4", 1'b1, 32'h8, 1'b1); chk_data("arst4", mem_word(32'h4), 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
